mem_arbiter: RTL and testbench

//  Shares the single-port, word-addressed data memory between the core's instruction-fetch

---
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between mem_arbiter, its two requesters (IF and D) and the data memory.
interface mem_arbiter_if;
  // fetch port
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  // load/store port
  logic        d_req_valid;
  logic [31:0] d_req_addr;
  logic        d_req_we;
  logic [31:0] d_req_wdata;
  logic        d_req_ready;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;
  logic        d_rsp_err;
  // memory side
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;
  // status
  logic        busy;

  // arbiter side
  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    input  d_req_valid, d_req_addr, d_req_we, d_req_wdata,
    output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    output mem_address, mem_write_data, mem_write_enable,
    input  mem_read_data,
    output busy
  );

  // requester / memory side
  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    output d_req_valid, d_req_addr, d_req_we, d_req_wdata,
    input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    input  mem_address, mem_write_data, mem_write_enable,
    output mem_read_data,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port data memory between the fetch (IF) and load/store (D) ports.
// One access in flight: IDLE -> ACCESS -> RESP -> IDLE, response two cycles after accept.
// Misaligned / out-of-range accesses never write memory; D gets an error, IF gets a NOP.
// Optional macro MEM_ARB_RR_EN: round-robin arbitration instead of fixed D-over-IF priority.
module mem_arbiter #(
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);
  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        grant_if;
  logic        grant_d;
  logic        accept;
  logic [31:0] sel_addr;
  logic        sel_err;
  logic        src_d;
  logic        we_q;
  logic        err_q;

`ifdef MEM_ARB_RR_EN
  logic        last_grant_d;
`endif

  // request selected by the current grant and its error classification
  assign accept   = grant_if | grant_d;
  assign sel_addr = grant_d ? bus.d_req_addr : bus.if_req_addr;
  assign sel_err  = (sel_addr[1:0] != 2'b00) | (sel_addr >= ADDR_LIMIT);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // next state, arbitration and response outputs
  always_comb begin
    state_next       = state;
    grant_if         = 1'b0;
    grant_d          = 1'b0;
    bus.if_req_ready = 1'b0;
    bus.d_req_ready  = 1'b0;
    bus.if_rsp_valid = 1'b0;
    bus.if_rsp_data  = 32'h0;
    bus.d_rsp_valid  = 1'b0;
    bus.d_rsp_data   = 32'h0;
    bus.d_rsp_err    = 1'b0;
    bus.busy         = (state != IDLE);
    case (state)
      IDLE: begin
`ifdef MEM_ARB_RR_EN
        if (bus.d_req_valid && bus.if_req_valid) begin
          grant_d  = ~last_grant_d;
          grant_if = last_grant_d;
        end else begin
          grant_d  = bus.d_req_valid;
          grant_if = bus.if_req_valid;
        end
`else
        grant_d  = bus.d_req_valid;
        grant_if = bus.if_req_valid & ~bus.d_req_valid;
`endif
        if (grant_if || grant_d) state_next = ACCESS;
      end
      ACCESS: state_next = RESP;
      RESP: begin
        state_next = IDLE;
        if (src_d) begin
          bus.d_rsp_valid = 1'b1;
          bus.d_rsp_err   = err_q;
          bus.d_rsp_data  = (we_q || err_q) ? 32'h0 : bus.mem_read_data;
        end else begin
          bus.if_rsp_valid = 1'b1;
          bus.if_rsp_data  = err_q ? NOP_INSN : bus.mem_read_data;
        end
      end
      default: state_next = IDLE;
    endcase
    bus.if_req_ready = grant_if;
    bus.d_req_ready  = grant_d;
  end

  // capture the accepted request; write strobe lives only for the ACCESS cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.mem_address      <= 32'h0;
      bus.mem_write_data   <= 32'h0;
      bus.mem_write_enable <= 1'b0;
      src_d                <= 1'b0;
      we_q                 <= 1'b0;
      err_q                <= 1'b0;
    end else if (accept) begin
      bus.mem_address      <= sel_addr;
      bus.mem_write_data   <= grant_d ? bus.d_req_wdata : 32'h0;
      bus.mem_write_enable <= grant_d & bus.d_req_we & ~sel_err;
      src_d                <= grant_d;
      we_q                 <= grant_d & bus.d_req_we;
      err_q                <= sel_err;
    end else begin
      bus.mem_write_enable <= 1'b0;
    end
  end

`ifdef MEM_ARB_RR_EN
  // remember which port won last so contention alternates
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       last_grant_d <= 1'b0;
    else if (accept) last_grant_d <= grant_d;
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural 1-cycle-latency memory.
module tb_mem_arbiter;

  localparam int unsigned MEM_WORDS = 64;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    logic [31:0] edata;
    logic        eerr;
    int          ewe;
  } vec_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];
  logic [31:0] mem [MEM_WORDS];

  mem_arbiter_if bus ();

  mem_arbiter #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: reset loads a known pattern, read data registered
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
      mem[2] <= 32'hDEAD_BEEF;
      bus.mem_read_data <= 32'h0;
    end else begin
      if (bus.mem_write_enable) mem[bus.mem_address[7:2]] <= bus.mem_write_data;
      bus.mem_read_data <= mem[bus.mem_address[7:2]];
    end
  end

  // drive one request, wait for acceptance, then watch until its response pulse
  task automatic run_access(input bit is_d, input logic [31:0] addr, input bit we,
                            input logic [31:0] wdata, output int wait_cyc, output int lat,
                            output logic [31:0] data, output logic err,
                            output int we_pulses, output bit other_rsp);
    bit accepted;
    accepted = 1'b0; wait_cyc = 0; lat = -1; data = 32'h0; err = 1'b0;
    we_pulses = 0; other_rsp = 1'b0;
    @(negedge clk);
    if (is_d) begin
      bus.d_req_valid = 1'b1; bus.d_req_addr = addr; bus.d_req_we = we; bus.d_req_wdata = wdata;
    end else begin
      bus.if_req_valid = 1'b1; bus.if_req_addr = addr;
    end
    #1;
    while (!accepted && wait_cyc < 20) begin
      if ((is_d && bus.d_req_ready) || (!is_d && bus.if_req_ready)) accepted = 1'b1;
      else begin
        @(negedge clk); #1; wait_cyc++;
      end
    end
    @(posedge clk); #1;
    if (is_d) bus.d_req_valid = 1'b0;
    else      bus.if_req_valid = 1'b0;
    if (!accepted) begin
      wait_cyc = -1;
      return;
    end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.mem_write_enable) we_pulses++;
      if (is_d ? bus.if_rsp_valid : bus.d_rsp_valid) other_rsp = 1'b1;
      if (is_d ? bus.d_rsp_valid : bus.if_rsp_valid) begin
        lat  = c;
        data = is_d ? bus.d_rsp_data : bus.if_rsp_data;
        err  = is_d ? bus.d_rsp_err : 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.if_req_ready !== 1'b0 || bus.d_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b%b expected 00", bus.if_req_ready, bus.d_req_ready); end
    n_checks++; if (bus.if_rsp_valid !== 1'b0 || bus.d_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b%b expected 00", bus.if_rsp_valid, bus.d_rsp_valid); end
    n_checks++; if (bus.d_rsp_err !== 1'b0 || bus.d_rsp_data !== 32'h0 || bus.if_rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data: got err=%b d=%h if=%h expected 0", bus.d_rsp_err, bus.d_rsp_data, bus.if_rsp_data); end
    n_checks++; if (bus.mem_write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b expected 0", bus.mem_write_enable); end
    n_checks++; if (bus.mem_address !== 32'h0 || bus.mem_write_data !== 32'h0) begin n_fail++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h expected 0", bus.mem_address, bus.mem_write_data); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_if_read();
    exp_t e; int wc, lat, wep; logic [31:0] data; logic err; bit oth;
    sb.push_back('{1'b0, 32'hDEAD_BEEF, 1'b0});
    run_access(1'b0, 32'h8, 1'b0, 32'h0, wc, lat, data, err, wep, oth);
    e = sb.pop_front();
    n_checks++; if (wc !== 0) begin n_fail++; $display("FAIL if_ready_cycle: got %0d expected 0", wc); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL if_latency: got %0d expected 2", lat); end
    n_checks++; if (data !== e.data) begin n_fail++; $display("FAIL if_data: got %h expected %h", data, e.data); end
    n_checks++; if (oth !== 1'b0) begin n_fail++; $display("FAIL if_d_rsp_quiet: got %b expected 0", oth); end
    n_checks++; if (wep !== 0) begin n_fail++; $display("FAIL if_no_write: got %0d expected 0", wep); end
  endtask

  task automatic test_store_load();
    vec_t v[2]; exp_t e; int wc, lat, wep; logic [31:0] data; logic err; bit oth;
    v[0] = '{1'b1, 32'h10, 1'b1, 32'h1234_5678, 32'h0, 1'b0, 1};
    v[1] = '{1'b1, 32'h10, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 0};
    foreach (v[i]) begin
      sb.push_back('{v[i].is_d, v[i].edata, v[i].eerr});
      run_access(v[i].is_d, v[i].addr, v[i].we, v[i].wdata, wc, lat, data, err, wep, oth);
      e = sb.pop_front();
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL sl[%0d]_latency: got %0d expected 2", i, lat); end
      n_checks++; if (data !== e.data) begin n_fail++; $display("FAIL sl[%0d]_data: got %h expected %h", i, data, e.data); end
      n_checks++; if (err !== e.err) begin n_fail++; $display("FAIL sl[%0d]_err: got %b expected %b", i, err, e.err); end
      n_checks++; if (wep !== v[i].ewe) begin n_fail++; $display("FAIL sl[%0d]_we_pulses: got %0d expected %0d", i, wep, v[i].ewe); end
      n_checks++; if (oth !== 1'b0) begin n_fail++; $display("FAIL sl[%0d]_other_rsp: got %b expected 0", i, oth); end
    end
  endtask

  task automatic test_errors();
    vec_t v[7]; exp_t e; int wc, lat, wep; logic [31:0] data; logic err; bit oth;
    v[0] = '{1'b1, 32'h11,  1'b1, 32'hFFFF_FFFF, 32'h0,         1'b1, 0};
    v[1] = '{1'b1, 32'h100, 1'b0, 32'h0,         32'h0,         1'b1, 0};
    v[2] = '{1'b1, 32'h10,  1'b0, 32'h0,         32'h1234_5678, 1'b0, 0};
    v[3] = '{1'b1, 32'hFC,  1'b0, 32'h0,         32'hA5A5_003F, 1'b0, 0};
    v[4] = '{1'b0, 32'h06,  1'b0, 32'h0,         32'h0000_0013, 1'b0, 0};
    v[5] = '{1'b0, 32'h100, 1'b0, 32'h0,         32'h0000_0013, 1'b0, 0};
    v[6] = '{1'b0, 32'hFC,  1'b0, 32'h0,         32'hA5A5_003F, 1'b0, 0};
    foreach (v[i]) begin
      sb.push_back('{v[i].is_d, v[i].edata, v[i].eerr});
      run_access(v[i].is_d, v[i].addr, v[i].we, v[i].wdata, wc, lat, data, err, wep, oth);
      e = sb.pop_front();
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL err[%0d]_latency: got %0d expected 2", i, lat); end
      n_checks++; if (data !== e.data) begin n_fail++; $display("FAIL err[%0d]_data: got %h expected %h", i, data, e.data); end
      n_checks++; if (err !== e.err) begin n_fail++; $display("FAIL err[%0d]_err: got %b expected %b", i, err, e.err); end
      n_checks++; if (wep !== v[i].ewe) begin n_fail++; $display("FAIL err[%0d]_we_pulses: got %0d expected %0d", i, wep, v[i].ewe); end
    end
  endtask

  task automatic test_back_to_back();
    bit order[4]; bit exp_order[4]; int n; int cyc;
`ifdef MEM_ARB_RR_EN
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    n = 0; cyc = 0;
    @(negedge clk);
    bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h8;
    bus.d_req_valid  = 1'b1; bus.d_req_addr  = 32'h10; bus.d_req_we = 1'b0;
    while (n < 4 && cyc < 40) begin
      #1;
      n_checks++;
      if (bus.if_req_ready && bus.d_req_ready) begin n_fail++; $display("FAIL b2b_double_grant: got 11 expected one-hot"); end
      if (bus.d_req_ready)       begin order[n] = 1'b1; n++; end
      else if (bus.if_req_ready) begin order[n] = 1'b0; n++; end
      if (n < 4) begin
        @(negedge clk); cyc++;
      end
    end
    @(posedge clk); #1;
    bus.if_req_valid = 1'b0; bus.d_req_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (n !== 4) begin n_fail++; $display("FAIL b2b_grant_count: got %0d expected 4", n); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i < n && order[i] !== exp_order[i]) begin n_fail++; $display("FAIL b2b_grant[%0d]: got d=%b expected d=%b", i, order[i], exp_order[i]); end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; int wc, lat, wep; logic [31:0] data; logic err; bit oth; bit pulsed; int w;
    @(negedge clk);
    bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h20; bus.d_req_we = 1'b1; bus.d_req_wdata = 32'hCAFE_F00D;
    #1; w = 0;
    while (!bus.d_req_ready && w < 20) begin @(negedge clk); #1; w++; end
    @(posedge clk); #1;
    bus.d_req_valid = 1'b0; bus.d_req_we = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.mem_write_enable !== 1'b1) begin n_fail++; $display("FAIL rm_we_in_access: got %b expected 1", bus.mem_write_enable); end
    n_checks++; if (bus.mem_address !== 32'h20) begin n_fail++; $display("FAIL rm_mem_address: got %h expected 00000020", bus.mem_address); end
    #1 reset = 1'b1;
    #1;
    n_checks++; if (bus.mem_write_enable !== 1'b0) begin n_fail++; $display("FAIL rm_we_async_drop: got %b expected 0", bus.mem_write_enable); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy_async: got %b expected 0", bus.busy); end
    pulsed = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.d_rsp_valid || bus.if_rsp_valid) pulsed = 1'b1;
    end
    reset = 1'b0;
    #1;
    n_checks++; if (pulsed !== 1'b0) begin n_fail++; $display("FAIL rm_no_rsp: got %b expected 0", pulsed); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy_after: got %b expected 0", bus.busy); end
    sb.push_back('{1'b1, 32'hA5A5_0008, 1'b0});
    run_access(1'b1, 32'h20, 1'b0, 32'h0, wc, lat, data, err, wep, oth);
    e = sb.pop_front();
    n_checks++; if (wc !== 0) begin n_fail++; $display("FAIL rm_new_accept: got %0d expected 0", wc); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL rm_new_latency: got %0d expected 2", lat); end
    n_checks++; if (data !== e.data) begin n_fail++; $display("FAIL rm_no_write: got %h expected %h", data, e.data); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b1;
    bus.if_req_valid = 1'b0; bus.if_req_addr = 32'h0;
    bus.d_req_valid  = 1'b0; bus.d_req_addr  = 32'h0;
    bus.d_req_we     = 1'b0; bus.d_req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    test_reset();
    test_if_read();
    test_store_load();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
